// File: rtl/wbgpio_seq.sv
// Wishbone master that replays a table of masked GPIO set/clear writes with per-step delays.
// Define GPIOSEQ_ABORT_EN to add the i_abort input.
module wbgpio_seq #(
  parameter int NSTEPS  = 8,
  parameter int LGSTEPS = 3,
  parameter int DELAYW  = 20,
  parameter int TIMEOUT = 255
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_cfg_we,
  input  logic [LGSTEPS-1:0]   i_cfg_addr,
  input  logic [32+DELAYW-1:0] i_cfg_data,
  input  logic                 i_start,
`ifdef GPIOSEQ_ABORT_EN
  input  logic                 i_abort,
`endif
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic [LGSTEPS-1:0]   o_step,
  output logic                 o_wb_cyc,
  output logic                 o_wb_stb,
  output logic                 o_wb_we,
  output logic [31:0]          o_wb_data,
  output logic [3:0]           o_wb_sel,
  input  logic                 i_wb_stall,
  input  logic                 i_wb_ack,
  input  logic                 i_wb_err
);
  typedef enum logic [1:0] {S_IDLE, S_STB, S_ACKW, S_DELAY} state_t;

  localparam logic [7:0]         TO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [LGSTEPS-1:0] LAST_STEP = LGSTEPS'(NSTEPS - 1);

  logic [32+DELAYW-1:0] table_q [NSTEPS];
  state_t               state;
  logic [7:0]           tcount;
  logic [DELAYW-1:0]    dcount;
  logic [LGSTEPS-1:0]   step_nxt;
  logic                 accept, wait_resp, resp_ok, resp_bad, seq_end, abort_now;

  assign o_wb_sel = 4'hf;

  // NOTE: the step table has no reset; its contents are undefined until loaded.
  always_ff @(posedge i_clk) begin
    if (i_cfg_we && state == S_IDLE)
      table_q[i_cfg_addr] <= i_cfg_data;
  end

`ifdef GPIOSEQ_ABORT_EN
  // An abort seen during a bus cycle is held until that cycle completes.
  logic abort_pend;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)           abort_pend <= 1'b0;
    else if (state == S_IDLE) abort_pend <= 1'b0;
    else if (i_abort)         abort_pend <= 1'b1;
  end
  assign abort_now = abort_pend | i_abort;
`else
  assign abort_now = 1'b0;
`endif

  assign step_nxt  = o_step + 1'b1;
  assign accept    = (state == S_STB) && !i_wb_stall;
  assign wait_resp = accept || (state == S_ACKW);
  assign resp_ok   = wait_resp && i_wb_ack && !i_wb_err;
  // tcount holds cycles since acceptance; o_err appears as it reaches TIMEOUT.
  assign resp_bad  = wait_resp && !resp_ok &&
                     (i_wb_err || (state == S_ACKW && tcount >= TO_LAST));
  assign seq_end   = (o_step == LAST_STEP) || (table_q[step_nxt][31:16] == 16'h0);

  // NOTE: every register below uses <=, so all decisions see pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= S_IDLE;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      o_step    <= '0;
      o_wb_cyc  <= 1'b0;
      o_wb_stb  <= 1'b0;
      o_wb_we   <= 1'b0;
      o_wb_data <= '0;
      tcount    <= '0;
      dcount    <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            o_step <= '0;
            o_err  <= 1'b0;
            if (table_q[0][31:16] == 16'h0) begin
              o_done <= 1'b1;
            end else begin
              state     <= S_STB;
              o_busy    <= 1'b1;
              o_wb_cyc  <= 1'b1;
              o_wb_stb  <= 1'b1;
              o_wb_we   <= 1'b1;
              o_wb_data <= table_q[0][31:0];
            end
          end
        end
        S_STB, S_ACKW: begin
          if (accept) begin
            state    <= S_ACKW;
            o_wb_stb <= 1'b0;
            tcount   <= 8'd1;
          end else if (state == S_ACKW) begin
            tcount <= tcount + 8'd1;
          end
          if (resp_bad || (resp_ok && abort_now)) begin
            state    <= S_IDLE;
            o_busy   <= 1'b0;
            o_err    <= 1'b1;
            o_wb_cyc <= 1'b0;
            o_wb_we  <= 1'b0;
          end else if (resp_ok) begin
            state    <= S_DELAY;
            o_wb_cyc <= 1'b0;
            o_wb_we  <= 1'b0;
            dcount   <= table_q[o_step][32 +: DELAYW];
          end
        end
        S_DELAY: begin
          if (abort_now) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
            o_err  <= 1'b1;
          end else if (dcount != '0) begin
            dcount <= dcount - DELAYW'(1);
          end else if (seq_end) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end else begin
            state     <= S_STB;
            o_step    <= step_nxt;
            o_wb_cyc  <= 1'b1;
            o_wb_stb  <= 1'b1;
            o_wb_we   <= 1'b1;
            o_wb_data <= table_q[step_nxt][31:0];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wbgpio_seq.sv
// Self-checking bench for wbgpio_seq: table-driven step programs, a Wishbone slave model
// and a scoreboard of expected bus writes.
`timescale 1ns/1ps
module tb_wbgpio_seq;
  localparam int NSTEPS  = 8;
  localparam int LGSTEPS = 3;
  localparam int DELAYW  = 20;
  localparam int TIMEOUT = 16;

  typedef enum int {R_ACK, R_ERR, R_NONE} resp_t;
  typedef struct { logic [DELAYW-1:0] delay; logic [15:0] mask; logic [15:0] value; } vec_t;
  typedef struct { logic [31:0] data; logic [LGSTEPS-1:0] step; } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 cfg_we = 1'b0;
  logic [LGSTEPS-1:0]   cfg_addr = '0;
  logic [32+DELAYW-1:0] cfg_data = '0;
  logic                 start = 1'b0;
  logic                 abort = 1'b0;
  logic                 busy, done, err;
  logic [LGSTEPS-1:0]   step;
  logic                 wb_cyc, wb_stb, wb_we;
  logic [31:0]          wb_data;
  logic [3:0]           wb_sel;
  logic                 wb_stall = 1'b0, wb_ack = 1'b0, wb_err = 1'b0;

  wbgpio_seq #(.NSTEPS(NSTEPS), .LGSTEPS(LGSTEPS), .DELAYW(DELAYW), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr), .i_cfg_data(cfg_data), .i_start(start),
`ifdef GPIOSEQ_ABORT_EN
    .i_abort(abort),
`endif
    .o_busy(busy), .o_done(done), .o_err(err), .o_step(step),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_data(wb_data), .o_wb_sel(wb_sel),
    .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_err(wb_err)
  );

  always #5 clk = ~clk;

  int    n_pass = 0, n_total = 0, cyc_no = 0;
  exp_t  sb[$];
  int    stb_starts[$], ack_cycles[$];
  int    done_cnt = 0, writes = 0, stall_obs = 0, accept_cycle = 0;
  int    stall_cfg = 0, stall_left = 0;
  resp_t resp = R_ACK;
  logic  pending = 1'b0, prev_stb = 1'b0, busy_seen = 1'b0;
  logic [31:0] held = '0;
  vec_t  va[3], vw[8];

  always @(posedge clk) cyc_no++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, exp, cyc_no);
  endtask

  // Slave model and scoreboard: sample on the falling edge, drive responses for this cycle.
  always @(negedge clk) begin
    exp_t e;
    wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0;
    if (!rst_n) begin
      pending = 1'b0; prev_stb = 1'b0; stall_left = 0;
    end else begin
      if (done) begin
        done_cnt++;
        check("done_with_busy_low", busy, 0);
      end
      if (busy) busy_seen = 1'b1;
      if (!wb_cyc) pending = 1'b0;
      if (wb_stb && !prev_stb) begin
        stb_starts.push_back(cyc_no);
        stall_left = stall_cfg;
        held = wb_data;
      end
      if (wb_stb) begin
        if (stall_left > 0) begin
          wb_stall = 1'b1;
          stall_left--;
          stall_obs++;
          check("stall_data_stable", wb_data, held);
        end else begin
          accept_cycle = cyc_no;
          writes++;
          if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_write: got 0x%08h, wanted no write", wb_data);
          end else begin
            e = sb.pop_front();
            check("wb_data", wb_data, e.data);
            check("wb_step", step, e.step);
            check("wb_we", wb_we, 1);
          end
          pending = 1'b1;
        end
      end else if (pending && wb_cyc) begin
        if (resp == R_ACK) begin
          wb_ack = 1'b1; ack_cycles.push_back(cyc_no); pending = 1'b0;
        end else if (resp == R_ERR) begin
          wb_err = 1'b1; pending = 1'b0;
        end
      end
      prev_stb = wb_stb;
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic load(input int idx, input vec_t v, input bit expect_write);
    exp_t e;
    cfg_we = 1'b1; cfg_addr = idx[LGSTEPS-1:0]; cfg_data = {v.delay, v.mask, v.value};
    tick();
    cfg_we = 1'b0;
    if (expect_write) begin
      e.data = {v.mask, v.value}; e.step = idx[LGSTEPS-1:0];
      sb.push_back(e);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int max_cycles);
    int k = 0;
    while (done_cnt == base && k < max_cycles) begin tick(); k++; end
    check("done_within_bound", done_cnt > base, 1);
  endtask

  task automatic wait_delay_of(input int s, input int max_cycles);
    int k = 0;
    while (!(int'(step) == s && busy && !wb_cyc) && k < max_cycles) begin tick(); k++; end
    check("reached_delay_state", k < max_cycles, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_step"}, step, 0);
    check({tag, "_cyc"}, wb_cyc, 0);
    check({tag, "_stb"}, wb_stb, 0);
    check({tag, "_we"}, wb_we, 0);
    check({tag, "_data"}, wb_data, 0);
    check({tag, "_sel"}, wb_sel, 4'hf);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int bd, bw, bs, ba, k;
    exp_t e;
    va[0] = '{20'd5, 16'h0003, 16'h0001};
    va[1] = '{20'd0, 16'h0002, 16'h0002};
    va[2] = '{20'd0, 16'h0000, 16'h0000};
    for (int i = 0; i < 8; i++)
      vw[i] = '{20'd0, 16'h0101 << i, 16'(i * 16'h1111)};

    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Two-step program with a 5-cycle delay and an end marker.
    for (int i = 0; i < 3; i++) load(i, va[i], i < 2);
    bd = done_cnt; bs = stb_starts.size(); ba = ack_cycles.size();
    pulse_start();
    check("start_busy", busy, 1);
    check("start_stb", wb_stb, 1);
    wait_done(bd, 60);
    repeat (3) tick();
    check("a_done_once", done_cnt - bd, 1);
    check("a_err", err, 0);
    check("a_sb_empty", sb.size(), 0);
    check("a_ack_to_stb_gap", stb_starts[bs + 1] - ack_cycles[ba], 7);

    // Empty table; a coincident table write must not be seen by that start.
    load(1, va[2], 0);
    load(0, va[2], 0);
    bw = writes; bd = done_cnt; busy_seen = 1'b0;
    cfg_we = 1'b1; cfg_addr = '0; cfg_data = {20'd0, 16'h00c0, 16'h0040}; start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    check("empty_done_next", done, 1);
    check("empty_stb", wb_stb, 0);
    repeat (3) tick();
    check("empty_no_write", writes - bw, 0);
    check("empty_busy_never", busy_seen, 0);
    check("empty_done_once", done_cnt - bd, 1);
    e.data = 32'h00c00040; e.step = '0; sb.push_back(e);
    bd = done_cnt;
    pulse_start();
    wait_done(bd, 40);
    check("cfg_collision_sb_empty", sb.size(), 0);

    // Slave stalls the strobe for 4 cycles.
    stall_cfg = 4;
    load(0, '{20'd0, 16'h00f0, 16'h0050}, 1);
    bw = writes; bd = done_cnt; bs = stall_obs;
    pulse_start();
    wait_done(bd, 40);
    stall_cfg = 0;
    check("stall_cycles", stall_obs - bs, 4);
    check("stall_one_write", writes - bw, 1);
    check("stall_sb_empty", sb.size(), 0);

    // Slave never acks: timeout, then a fresh start clears o_err.
    resp = R_NONE;
    load(0, '{20'd0, 16'h0001, 16'h0001}, 1);
    bd = done_cnt;
    pulse_start();
    k = 0;
    while (!err && k < 40) begin tick(); k++; end
    check("timeout_err_set", err, 1);
    check("timeout_latency", cyc_no - accept_cycle, TIMEOUT);
    check("timeout_cyc_drop", wb_cyc, 0);
    check("timeout_busy_drop", busy, 0);
    check("timeout_no_done", done_cnt - bd, 0);
    resp = R_ACK;
    e.data = 32'h00010001; e.step = '0; sb.push_back(e);
    pulse_start();
    check("restart_clears_err", err, 0);
    wait_done(bd, 40);

    // Slave error response.
    resp = R_ERR;
    sb.push_back(e);
    bd = done_cnt;
    pulse_start();
    k = 0;
    while (!err && k < 10) begin tick(); k++; end
    check("slave_err_set", err, 1);
    check("slave_err_cyc_drop", wb_cyc, 0);
    check("slave_err_no_done", done_cnt - bd, 0);
    resp = R_ACK;

    // All eight entries live with zero delay.
    for (int i = 0; i < 8; i++) load(i, vw[i], 1);
    bw = writes; bd = done_cnt; bs = stb_starts.size();
    pulse_start();
    wait_done(bd, 200);
    check("walk_writes", writes - bw, 8);
    check("walk_sb_empty", sb.size(), 0);
    for (int i = 1; i < 8; i++) check("walk_stb_spacing", stb_starts[bs + i] - stb_starts[bs + i - 1], 3);

    // Asynchronous reset during the delay of step 2.
    for (int i = 0; i < 4; i++) load(i, '{20'd10, 16'h0010 << i, 16'hffff}, i < 3);
    load(4, va[2], 0);
    pulse_start();
    wait_delay_of(2, 200);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    check("reset_sb_empty", sb.size(), 0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();

`ifdef GPIOSEQ_ABORT_EN
    // Abort during a delay ends the run next cycle with an error.
    for (int i = 0; i < 3; i++) load(i, '{20'd10, 16'h0100 << i, 16'h0000}, i < 2);
    load(3, va[2], 0);
    bd = done_cnt;
    pulse_start();
    wait_delay_of(1, 200);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy_drop", busy, 0);
    check("abort_err", err, 1);
    check("abort_cyc", wb_cyc, 0);
    check("abort_no_done", done_cnt - bd, 0);
    check("abort_sb_empty", sb.size(), 0);
    sb.delete();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/wbgpio_seq.md
# wbgpio_seq

Wishbone-master sequencer that replays a programmable table of masked GPIO output writes, with a per-step delay, into a single-address set/clear GPIO port: bits [31:16] select outputs, bits [15:0] give their new values. It sits between host/board-bring-up logic and the GPIO controller and drives timed power-up, PHY-reset and LED sequences without CPU involvement. The step table is loaded through a simple write port. A sequence runs on a start pulse and reports done or bus error.

## Interface
- `NSTEPS`, default 8: table depth, power of two, 2..64.
- `LGSTEPS`, default 3: log2(`NSTEPS`).
- `DELAYW`, default 20: width of the per-step delay counter.
- `TIMEOUT`, default 255: maximum cycles from strobe acceptance to ack, 1..255.

Ports:
- `i_clk` in 1: clock.
- `i_reset_n` in 1: asynchronous, active-low reset.
- `i_cfg_we` in 1: table write strobe. Ignored while busy.
- `i_cfg_addr` in `LGSTEPS`: table index.
- `i_cfg_data` in 32+`DELAYW`: entry = {delay[`DELAYW`-1:0], mask[15:0], value[15:0]}.
- `i_start` in 1: single-cycle start pulse. Ignored while busy.
- `i_abort` in 1: abort request. Present only with `GPIOSEQ_ABORT_EN`.
- `o_busy` out 1: sequence active.
- `o_done` out 1: one-cycle pulse when a sequence ends normally.
- `o_err` out 1: sticky bus error or timeout. Cleared by `i_start`.
- `o_step` out `LGSTEPS`: current step index.
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we` out 1: master bus controls.
- `o_wb_data` out 32: {mask, value}.
- `o_wb_sel` out 4: constant 4'hf.
- `i_wb_stall`, `i_wb_ack`, `i_wb_err` in 1: slave responses.

## Operation
- Table: `NSTEPS` entries in registers. Contents are undefined after reset. An entry with mask==0 is an end marker.
- States: IDLE, STB, ACKW, DELAY.
- IDLE:
  - `i_start` sets step=0 and clears `o_err`.
  - If entry[0].mask==0: pulse `o_done` and stay IDLE.
  - Otherwise go to STB.
- STB:
  - `o_wb_cyc`=`o_wb_stb`=`o_wb_we`=1 and `o_wb_data`={mask,value}.
  - Hold until `!i_wb_stall`, then go to ACKW with stb=0 and cyc=1.
  - An ack in the same cycle as the accepting strobe goes directly to DELAY.
- ACKW:
  - `i_wb_ack` leads to DELAY with cyc=0, and loads the counter with the delay field.
  - `i_wb_err`, or the timeout counter reaching `TIMEOUT`, sets `o_err`, drops cyc and goes to IDLE without a `o_done` pulse.
- DELAY:
  - Decrement the counter each cycle; at 0, advance the step.
  - If step==`NSTEPS`-1 or the next entry's mask==0: pulse `o_done` and go to IDLE.
  - Otherwise go to STB.
- Step index increments modulo `NSTEPS`. It never wraps within one run.
- A slave error is recorded only in ACKW (or on the accepting cycle in STB). `i_wb_err` in any other state is ignored.
- `o_wb_cyc` drops for at least one cycle between consecutive steps.

## Timing
- Reset values:
  - state=IDLE.
  - All bus outputs 0, except `o_wb_sel`=4'hf.
  - `o_busy`=0, `o_done`=0, `o_err`=0, `o_step`=0.
  - Timeout and delay counters = 0.
- `i_start` at cycle 0 gives `o_busy`=1 and `o_wb_stb`=1 at cycle 1. All outputs are registered.
- A step with delay D and zero-wait slave (ack the cycle after strobe): stb in cycle n, ack in cycle n+1, next stb in cycle n+3+D. D=0 is legal.
- `o_done` is asserted in the same cycle `o_busy` falls.
- `i_cfg_we` coincident with `i_start` in IDLE: the write takes effect and start reads the old entry 0.
- Reset mid-operation drops cyc/stb immediately, asynchronously.

## Configuration
- `GPIOSEQ_ABORT_EN` defined: `i_abort` exists.
  - In STB or ACKW, the pending cycle completes (ack, err or timeout), then the block goes to IDLE.
  - In DELAY it goes to IDLE next cycle.
  - Abort sets `o_err`, with no `o_done` pulse.
  - `i_abort` in IDLE has no effect.
- `GPIOSEQ_ABORT_EN` undefined: the port is absent and the sequence cannot be aborted.

## Test plan
- Program entries {5,0x0003,0x0001}, {0,0x0002,0x0002} and an end marker, then pulse start. Required:
  - Bus writes 0x00030001 and then 0x00020002.
  - Gap from first ack to second stb is 5+2 cycles.
  - `o_done` pulses once and `o_err` stays 0.
- Entry[0].mask=0 plus start -> `o_done` pulses the next cycle with no bus cycle and `o_busy` never set.
- Slave holds `i_wb_stall`=1 for 4 cycles -> stb and data are stable throughout, and exactly one write is accepted.
- Slave never acks with `TIMEOUT`=16 -> `o_err`=1 sixteen cycles after acceptance, cyc drops, and the next `i_start` clears `o_err`.
- All 8 entries nonzero with delay 0 -> 8 writes, `o_step` walks 0..7, then `o_done`.
- Assert `i_reset_n` low during DELAY of step 2 -> all outputs return to reset values asynchronously. With `GPIOSEQ_ABORT_EN`, abort in DELAY -> IDLE next cycle with `o_err`=1.
